// File: rtl/dag2_pkg.sv
// Shared types and constants for the dag2 round-robin scheduler.
package dag2_pkg;

   localparam int unsigned DEFAULT_BITS     = 2;
   localparam int unsigned DEFAULT_CNT_BITS = 8;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StAdd1 = 3'd1,
      StSub  = 3'd2,
      StAdd2 = 3'd3,
      StDone = 3'd4
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/dag2_addsub.sv
// Shared BITS-wide adder/subtractor; the cout port exists only when DAG2_OVF_EN is defined.
module dag2_addsub
   import dag2_pkg::*;
#(
   parameter int unsigned BITS = DEFAULT_BITS
) (
   input  logic [BITS-1:0] x,
   input  logic [BITS-1:0] y,
   input  logic            op,
   output logic [BITS-1:0] res
`ifdef DAG2_OVF_EN
   ,
   output logic            cout
`endif
);

`ifdef DAG2_OVF_EN
   logic [BITS:0] wide;

   // Top bit is carry for add and borrow for sub.
   always_comb begin
      if (op == OP_SUB) begin
         wide = {1'b0, x} - {1'b0, y};
      end else begin
         wide = {1'b0, x} + {1'b0, y};
      end
      res  = wide[BITS-1:0];
      cout = wide[BITS];
   end
`else
   always_comb begin
      if (op == OP_SUB) begin
         res = x - y;
      end else begin
         res = x + y;
      end
   end
`endif

endmodule

// File: rtl/dag2_rr_sched.sv
// Two-requester round-robin scheduler computing (a+b)+((a+b)-b) on one shared add/sub unit.
// Defining DAG2_OVF_EN adds an ovf output flagging any carry/borrow seen during the job.
module dag2_rr_sched
   import dag2_pkg::*;
#(
   parameter int unsigned BITS     = DEFAULT_BITS,
   parameter int unsigned CNT_BITS = DEFAULT_CNT_BITS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [BITS-1:0]     req0_a,
   input  logic [BITS-1:0]     req0_b,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [BITS-1:0]     req1_a,
   input  logic [BITS-1:0]     req1_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITS-1:0]     out,
   output logic                out_id,
   output logic                busy,
   output logic [CNT_BITS-1:0] done_count
`ifdef DAG2_OVF_EN
   ,
   output logic                ovf
`endif
);

   state_e            state_q, state_d;
   logic [BITS-1:0]   a_q, b_q, t1_q, t2_q, out_q;
   logic              id_q, out_id_q, last_grant_q;
   logic [CNT_BITS-1:0] cnt_q;

   logic              gnt_any, gnt_id, accept;
   logic [BITS-1:0]   alu_x, alu_y, alu_res;
   logic              alu_op;

   // A tie goes to whichever requester was not granted last.
   assign gnt_any    = req0_valid | req1_valid;
   assign gnt_id     = req1_valid & (~req0_valid | ~last_grant_q);
   assign accept     = (state_q == StIdle) & gnt_any & ~reset;
   assign req0_ready = accept & ~gnt_id;
   assign req1_ready = accept & gnt_id;

   assign out_valid  = (state_q == StDone);
   assign busy       = (state_q != StIdle);
   assign out        = out_q;
   assign out_id     = out_id_q;
   assign done_count = cnt_q;

   always_comb begin
      state_d = state_q;
      alu_x   = '0;
      alu_y   = '0;
      alu_op  = OP_ADD;
      case (state_q)
         StIdle: if (accept) state_d = StAdd1;
         StAdd1: begin
            alu_x   = a_q;
            alu_y   = b_q;
            state_d = StSub;
         end
         StSub: begin
            alu_x   = t1_q;
            alu_y   = b_q;
            alu_op  = OP_SUB;
            state_d = StAdd2;
         end
         StAdd2: begin
            alu_x   = t1_q;
            alu_y   = t2_q;
            state_d = StDone;
         end
         StDone: if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

`ifdef DAG2_OVF_EN
   logic alu_cout;
   logic ovf_q;

   dag2_addsub #(
      .BITS (BITS)
   ) u_alu (
      .x    (alu_x),
      .y    (alu_y),
      .op   (alu_op),
      .res  (alu_res),
      .cout (alu_cout)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if (state_q == StAdd1 || state_q == StSub || state_q == StAdd2) begin
         ovf_q <= ovf_q | alu_cout;
      end
   end

   assign ovf = ovf_q;
`else
   dag2_addsub #(
      .BITS (BITS)
   ) u_alu (
      .x   (alu_x),
      .y   (alu_y),
      .op  (alu_op),
      .res (alu_res)
   );
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         a_q          <= '0;
         b_q          <= '0;
         t1_q         <= '0;
         t2_q         <= '0;
         out_q        <= '0;
         id_q         <= 1'b0;
         out_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  a_q          <= gnt_id ? req1_a : req0_a;
                  b_q          <= gnt_id ? req1_b : req0_b;
                  id_q         <= gnt_id;
                  last_grant_q <= gnt_id;
               end
            end
            StAdd1: t1_q <= alu_res;
            StSub:  t2_q <= alu_res;
            StAdd2: begin
               out_q    <= alu_res;
               out_id_q <= id_q;
            end
            StDone: if (out_ready) cnt_q <= cnt_q + CNT_BITS'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dag2_rr_sched.sv
// Self-checking bench for dag2_rr_sched: one 8-bit instance and one 2-bit instance with a 2-bit counter.
module tb_dag2_rr_sched;

   typedef struct {
      logic       id;
      logic [7:0] val;
      logic       ovf;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_fail = 0;
   exp_t sb[$];

   // Wide instance (BITS=8, CNT_BITS=8)
   logic       w_r0v = 0, w_r1v = 0, w_ordy = 0;
   logic [7:0] w_r0a = 0, w_r0b = 0, w_r1a = 0, w_r1b = 0;
   logic       w_r0rdy, w_r1rdy, w_ov, w_id, w_busy;
   logic [7:0] w_out, w_cnt;
   // Narrow instance (BITS=2, CNT_BITS=2)
   logic       n_r0v = 0, n_r1v = 0, n_ordy = 0;
   logic [1:0] n_r0a = 0, n_r0b = 0, n_r1a = 0, n_r1b = 0;
   logic       n_r0rdy, n_r1rdy, n_ov, n_id, n_busy;
   logic [1:0] n_out, n_cnt;
`ifdef DAG2_OVF_EN
   logic       w_ovf, n_ovf;
`endif

   dag2_rr_sched #(.BITS(8), .CNT_BITS(8)) dut_w (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (w_r0v),
      .req0_ready (w_r0rdy),
      .req0_a     (w_r0a),
      .req0_b     (w_r0b),
      .req1_valid (w_r1v),
      .req1_ready (w_r1rdy),
      .req1_a     (w_r1a),
      .req1_b     (w_r1b),
      .out_valid  (w_ov),
      .out_ready  (w_ordy),
      .out        (w_out),
      .out_id     (w_id),
      .busy       (w_busy),
      .done_count (w_cnt)
`ifdef DAG2_OVF_EN
      ,
      .ovf        (w_ovf)
`endif
   );

   dag2_rr_sched #(.BITS(2), .CNT_BITS(2)) dut_n (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (n_r0v),
      .req0_ready (n_r0rdy),
      .req0_a     (n_r0a),
      .req0_b     (n_r0b),
      .req1_valid (n_r1v),
      .req1_ready (n_r1rdy),
      .req1_a     (n_r1a),
      .req1_b     (n_r1b),
      .out_valid  (n_ov),
      .out_ready  (n_ordy),
      .out        (n_out),
      .out_id     (n_id),
      .busy       (n_busy),
      .done_count (n_cnt)
`ifdef DAG2_OVF_EN
      ,
      .ovf        (n_ovf)
`endif
   );

   function automatic exp_t model(input int bits, input logic id, input int a, input int b);
      exp_t e;
      int mask, t1, t2, r;
      mask = (1 << bits) - 1;
      t1 = (a + b) & mask;
      t2 = (t1 - b) & mask;
      r  = (t1 + t2) & mask;
      e.id  = id;
      e.val = 8'(r);
      e.ovf = ((a + b) > mask) || (t1 < b) || ((t1 + t2) > mask);
      return e;
   endfunction

   // Waits (bounded) for the selected ready; call just after a negedge with inputs applied.
   task automatic wait_rdy(input bit narrow, input bit which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (narrow ? (which ? n_r1rdy : n_r0rdy) : (which ? w_r1rdy : w_r0rdy)) begin
            ok = 1'b1;
            return;
         end
         @(negedge clock);
      end
   endtask

   task automatic wait_out(input bit narrow, output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 12; i++) begin
         if (narrow ? n_ov : w_ov) begin
            ok = 1'b1;
            return;
         end
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      w_r0v = 1'b1;
      w_r1v = 1'b1;
      n_r0v = 1'b1;
      #1;
      n_cmp++;
      if ({w_ov, w_busy, w_id, w_r0rdy, w_r1rdy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_w_ctrl: got %b want 00000", {w_ov, w_busy, w_id, w_r0rdy, w_r1rdy});
      end
      n_cmp++;
      if (w_out !== 8'd0 || w_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_w_data: out=%0d cnt=%0d want 0/0", w_out, w_cnt);
      end
      n_cmp++;
      if ({n_ov, n_busy, n_id, n_r0rdy, n_r1rdy, n_out, n_cnt} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_n: got %b want 0",
                  {n_ov, n_busy, n_id, n_r0rdy, n_r1rdy, n_out, n_cnt});
      end
      @(negedge clock);
      reset = 1'b0;
      w_r0v = 1'b0;
      w_r1v = 1'b0;
      n_r0v = 1'b0;
   endtask

   task automatic test_basic();
      bit ok;
      int cyc;
      exp_t e;
      @(negedge clock);
      w_r0a = 8'd10; w_r0b = 8'd3; w_r0v = 1'b1; w_ordy = 1'b1;
      wait_rdy(1'b0, 1'b0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_accept: req0_ready got 0 want 1");
         w_r0v = 1'b0;
         return;
      end
      sb.push_back(model(8, 1'b0, 10, 3));
      @(negedge clock);
      w_r0v = 1'b0;
      wait_out(1'b0, ok, cyc);
      n_cmp++;
      if (!ok || cyc + 1 != 4) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d cycles (seen=%0b) want 4", cyc + 1, ok);
      end
      e = sb.pop_front();
      n_cmp++;
      if (w_out !== e.val || w_id !== e.id) begin
         n_fail++;
         $display("FAIL basic_out: got %0d/id%0d want %0d/id%0d", w_out, w_id, e.val, e.id);
      end
`ifdef DAG2_OVF_EN
      n_cmp++;
      if (w_ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL basic_ovf: got %0b want %0b", w_ovf, e.ovf);
      end
`endif
      @(negedge clock);
      n_cmp++;
      if (w_cnt !== 8'd1 || w_ov !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_count: cnt=%0d valid=%0b want 1/0", w_cnt, w_ov);
      end
   endtask

   task automatic test_bits2();
      bit ok;
      int cyc;
      exp_t e;
      @(negedge clock);
      n_r1a = 2'd3; n_r1b = 2'd2; n_r1v = 1'b1; n_ordy = 1'b1;
      wait_rdy(1'b1, 1'b1, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bits2_accept: req1_ready got 0 want 1");
         n_r1v = 1'b0;
         return;
      end
      sb.push_back(model(2, 1'b1, 3, 2));
      @(negedge clock);
      n_r1v = 1'b0;
      wait_out(1'b1, ok, cyc);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || n_out !== e.val[1:0] || n_id !== e.id) begin
         n_fail++;
         $display("FAIL bits2_out: got %0d/id%0d want %0d/id%0d", n_out, n_id, e.val[1:0], e.id);
      end
`ifdef DAG2_OVF_EN
      n_cmp++;
      if (n_ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL bits2_ovf: got %0b want %0b", n_ovf, e.ovf);
      end
`endif
      @(negedge clock);
   endtask

   task automatic test_round_robin();
      exp_t e;
      bit   exp_gnt;
      int   outs;
      pulse_reset();
      w_r0a = 8'd1; w_r0b = 8'd1; w_r1a = 8'd2; w_r1b = 8'd0;
      w_r0v = 1'b1; w_r1v = 1'b1; w_ordy = 1'b1;
      exp_gnt = 1'b0;
      outs = 0;
      for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
         #1;
         n_cmp++;
         if (w_r0rdy && w_r1rdy) begin
            n_fail++;
            $display("FAIL rr_both_ready: got 11 want at most one");
         end
         if (w_r0rdy || w_r1rdy) begin
            n_cmp++;
            if (w_r1rdy !== exp_gnt) begin
               n_fail++;
               $display("FAIL rr_grant: got id%0b want id%0b", w_r1rdy, exp_gnt);
            end
            sb.push_back(w_r1rdy ? model(8, 1'b1, 2, 0) : model(8, 1'b0, 1, 1));
            exp_gnt = ~exp_gnt;
         end
         if (w_ov && w_ordy && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (w_out !== e.val || w_id !== e.id) begin
               n_fail++;
               $display("FAIL rr_out: got %0d/id%0d want %0d/id%0d", w_out, w_id, e.val, e.id);
            end
            outs++;
            if (outs == 4) begin
               w_r0v = 1'b0;
               w_r1v = 1'b0;
            end
         end
         @(negedge clock);
      end
      w_r0v = 1'b0;
      w_r1v = 1'b0;
      n_cmp++;
      if (outs != 4 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL rr_jobs: got %0d outputs (%0d pending) want 4 (0)", outs, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_backpressure();
      bit   ok;
      int   cyc;
      exp_t e;
      logic [7:0] cnt0;
      @(negedge clock);
      w_r0a = 8'd5; w_r0b = 8'd7; w_r0v = 1'b1; w_ordy = 1'b0;
      wait_rdy(1'b0, 1'b0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_accept: req0_ready got 0 want 1");
         w_r0v = 1'b0;
         return;
      end
      sb.push_back(model(8, 1'b0, 5, 7));
      @(negedge clock);
      w_r0v = 1'b0;
      wait_out(1'b0, ok, cyc);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_valid: out_valid got 0 want 1");
      end
      e = sb[0];
      cnt0 = w_cnt;
      w_r0v = 1'b1;
      w_r1v = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if (w_out !== e.val || w_id !== e.id || w_busy !== 1'b1 || w_ov !== 1'b1 ||
             w_r0rdy !== 1'b0 || w_r1rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: out=%0d id=%0b busy=%0b v=%0b rdy=%0b%0b want %0d/%0b/1/1/00",
                     w_out, w_id, w_busy, w_ov, w_r0rdy, w_r1rdy, e.val, e.id);
         end
         @(negedge clock);
      end
      w_ordy = 1'b1;
      w_r0v = 1'b0;
      w_r1v = 1'b0;
      e = sb.pop_front();
      @(negedge clock);
      n_cmp++;
      if (w_cnt !== cnt0 + 8'd1 || w_ov !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: cnt=%0d valid=%0b want %0d/0", w_cnt, w_ov, cnt0 + 8'd1);
      end
      @(negedge clock);
      n_cmp++;
      if (w_cnt !== cnt0 + 8'd1) begin
         n_fail++;
         $display("FAIL bp_count_once: cnt=%0d want %0d", w_cnt, cnt0 + 8'd1);
      end
   endtask

   task automatic test_reset_mid();
      bit   ok;
      int   cyc;
      exp_t e;
      @(negedge clock);
      w_r0a = 8'd9; w_r0b = 8'd4; w_r0v = 1'b1; w_ordy = 1'b1;
      wait_rdy(1'b0, 1'b0, ok);
      @(negedge clock);
      w_r0v = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (!ok || w_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_busy: busy=%0b seen=%0b want 1/1", w_busy, ok);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (w_busy !== 1'b0 || w_ov !== 1'b0 || w_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL rmid_clear: busy=%0b valid=%0b cnt=%0d want 0/0/0", w_busy, w_ov, w_cnt);
      end
      @(negedge clock);
      reset = 1'b0;
      w_r0a = 8'd6; w_r0b = 8'd1; w_r1a = 8'd2; w_r1b = 8'd2;
      w_r0v = 1'b1; w_r1v = 1'b1;
      #1;
      n_cmp++;
      if (w_r0rdy !== 1'b1 || w_r1rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_tie: rdy=%0b%0b want 10", w_r0rdy, w_r1rdy);
      end
      sb.push_back(model(8, 1'b0, 6, 1));
      @(negedge clock);
      w_r0v = 1'b0;
      w_r1v = 1'b0;
      wait_out(1'b0, ok, cyc);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || w_out !== e.val || w_id !== e.id) begin
         n_fail++;
         $display("FAIL rmid_out: got %0d/id%0d want %0d/id%0d", w_out, w_id, e.val, e.id);
      end
      @(negedge clock);
      n_cmp++;
      if (w_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL rmid_count: cnt=%0d want 1", w_cnt);
      end
   endtask

   task automatic test_count_wrap();
      bit   ok;
      int   cyc;
      exp_t e;
      logic [1:0] exp_cnt;
      pulse_reset();
      n_ordy = 1'b1;
      for (int j = 0; j < 5; j++) begin
         n_r0a = 2'(j);
         n_r0b = 2'(j + 1);
         n_r0v = 1'b1;
         wait_rdy(1'b1, 1'b0, ok);
         if (ok) sb.push_back(model(2, 1'b0, j % 4, (j + 1) % 4));
         @(negedge clock);
         n_r0v = 1'b0;
         wait_out(1'b1, ok, cyc);
         n_cmp++;
         if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL wrap_job%0d: no result (valid=%0b) want a result", j, n_ov);
         end else begin
            e = sb.pop_front();
            n_cmp++;
            if (n_out !== e.val[1:0] || n_id !== e.id) begin
               n_fail++;
               $display("FAIL wrap_out%0d: got %0d want %0d", j, n_out, e.val[1:0]);
            end
`ifdef DAG2_OVF_EN
            n_cmp++;
            if (n_ovf !== e.ovf) begin
               n_fail++;
               $display("FAIL wrap_ovf%0d: got %0b want %0b", j, n_ovf, e.ovf);
            end
`endif
         end
         @(negedge clock);
         exp_cnt = 2'(j + 1);
         n_cmp++;
         if (n_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_count%0d: got %0d want %0d", j, n_cnt, exp_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bits2();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
